muldiv_ctrl: RTL

Iterative multiply/divide sequencer for the execute stage. It owns the HI/LO registers and runs 32-cycle unsigned shift-add multiply and restoring divide. While an operation is in flight it stalls any dependent MFHI/MFLO. It sits beside the single-cycle `alu` in EX. The `alu` keeps handling ADD/SUB/AND/OR/SLT; this block takes the HI/LO-class functs.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - funct encodings of the HI/LO-class instructions handled in EX
//   - sequencer state enum
package muldiv_pkg;

  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the shift-add multiply or restoring divide.
// Ports:
//   mode   - S_MUL selects multiply step, S_DIV selects divide step
//   w      - current 64-bit working register ({acc} or {rem, quo})
//   opnd   - multiplicand (MUL) or divisor (DIV)
//   w_next - working register after this iteration
module muldiv_step
  import muldiv_pkg::*;
(
  input  state_e      mode,
  input  logic [63:0] w,
  input  logic [31:0] opnd,
  output logic [63:0] w_next
);

  logic [32:0] mul_sum;
  logic [63:0] div_sh;
  logic [32:0] div_diff;
  logic        div_ge;

  always_comb begin
    // Multiply: conditionally add into the upper half, then shift {carry, acc} right.
    mul_sum = {1'b0, w[63:32]} + (w[0] ? {1'b0, opnd} : 33'd0);

    // Divide: w[63] is the remainder bit shifted out; it takes part in the trial so a
    // remainder at or above 2^31 is not lost. If it is set the trial always succeeds.
    div_sh   = {w[62:0], 1'b0};
    div_diff = {w[63], div_sh[63:32]} - {1'b0, opnd};
    div_ge   = w[63] | ~div_diff[32];

    if (mode == S_DIV) begin
      w_next = div_ge ? {div_diff[31:0], div_sh[31:1], 1'b1} : div_sh;
    end else begin
      w_next = {mul_sum, w[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative unsigned MULTU/DIVU sequencer owning architectural HI/LO.
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   e_start, e_funct  - muldiv-class instruction in EX and its funct
//   e_aluA, e_aluB    - rs / rt operand values
//   e_mfreq           - MFHI/MFLO in EX this cycle
//   e_flush           - pipeline flush, aborts in-flight work
//   e_busy, e_stall   - operation in progress / stall of a dependent MFHI/MFLO
//   e_hi, e_lo        - architectural HI/LO
//   e_dbz             - one-cycle pulse when a DIVU by zero completes
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        e_start,
  input  logic [5:0]  e_funct,
  input  logic [31:0] e_aluA,
  input  logic [31:0] e_aluB,
  input  logic        e_mfreq,
  input  logic        e_flush,
  output logic        e_busy,
  output logic        e_stall,
  output logic [31:0] e_hi,
  output logic [31:0] e_lo,
  output logic        e_dbz
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [63:0]       acc_q, acc_d;
  logic [31:0]       opnd_q, opnd_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              dbz_q, dbz_d;
  logic [63:0]       step_w;

  muldiv_step u_step (
    .mode   (state_q),
    .w      (acc_q),
    .opnd   (opnd_q),
    .w_next (step_w)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (e_start && !e_flush) begin
          case (e_funct)
            FN_MULTU: begin
              acc_d   = {32'd0, e_aluB};
              opnd_d  = e_aluA;
              cnt_d   = CntW'(ITER - 1);
              state_d = S_MUL;
            end
            FN_DIVU: begin
              acc_d   = {32'd0, e_aluA};
              opnd_d  = e_aluB;
              cnt_d   = CntW'(ITER - 1);
              state_d = S_DIV;
            end
            FN_MTHI: hi_d = e_aluA;
            FN_MTLO: lo_d = e_aluA;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (e_flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_w;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            // Last iteration: commit results straight from the step output.
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = step_w[63:32];
            lo_d    = step_w[31:0];
            dbz_d   = (state_q == S_DIV) && (opnd_q == 32'd0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign e_busy  = (state_q != S_IDLE);
  assign e_stall = e_busy & e_mfreq;
  assign e_hi    = hi_q;
  assign e_lo    = lo_q;
  assign e_dbz   = dbz_q;

endmodule
